// File: rtl/posit_round_pkg.sv
// Shared types, default widths and regime-to-fraction-length helper for the posit round stage.
// Used by posit_frac_round_p, whose RNE rounding is enabled with POSIT_ROUND_RNE_EN.
package posit_round_pkg;

    localparam int DEF_IN_W    = 64;
    localparam int DEF_OUT_W   = 32;
    localparam int DEF_K_W     = 6;
    localparam int DEF_NBT_POS = 26;
    localparam int DEF_NBT_NEG = 27;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MASK,
        ROUND,
        DONE
    } state_t;

    function automatic int nbt_calc(input int k_s, input int k_w, input int nbt_pos,
                                    input int nbt_neg, input int out_w);
        int abs_k;
        int nbt;
        // |k| is a k_w-bit negate: the most negative k stays negative, pushing nbt to the top clamp
        abs_k = (k_s == -(1 << (k_w - 1))) ? k_s : -k_s;
        nbt   = (k_s >= 0) ? (nbt_pos - k_s) : (nbt_neg - abs_k);
        if (nbt < 0) begin
            nbt = 0;
        end else if (nbt > out_w) begin
            nbt = out_w;
        end
        return nbt;
    endfunction

endpackage

// File: rtl/round_mask_gen.sv
// Combinational decode of the kept-fraction length nbt into keep mask, kept-LSB one-hot
// and the mask of bits below the guard position.
module round_mask_gen #(
    parameter int OUT_W = 32,
    parameter int NBT_W = $clog2(OUT_W + 1)
) (
    input  logic [NBT_W-1:0] nbt_i,
    output logic [OUT_W-1:0] mask_o,
    output logic [OUT_W-1:0] lsb_oh_o,
    output logic [OUT_W-1:0] stk_mask_o
);

    localparam logic [OUT_W-1:0] ONES = '1;
    localparam logic [OUT_W-1:0] ONE  = OUT_W'(1);

    always_comb begin
        mask_o     = ~(ONES >> nbt_i);
        stk_mask_o = (~mask_o) >> 1;
        lsb_oh_o   = (nbt_i == '0) ? '0 : (ONE << (OUT_W - int'(nbt_i)));
    end

endmodule

// File: rtl/posit_frac_round_p.sv
// Posit fraction extractor/rounder: keeps nbt fraction MSBs, truncates or rounds to nearest-even.
// Define POSIT_ROUND_RNE_EN for RNE; otherwise pure truncation with identical latency.
module posit_frac_round_p
    import posit_round_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int K_W     = DEF_K_W,
    parameter int NBT_POS = DEF_NBT_POS,
    parameter int NBT_NEG = DEF_NBT_NEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  mant_in,
    input  logic [K_W-1:0]   k_in,
    output logic [OUT_W-1:0] mant_out,
    output logic             round_cy,
    output logic             inexact,
    output logic             busy,
    output logic             done
);

    localparam int NBT_W = $clog2(OUT_W + 1);
    localparam int LOW_W = IN_W - 2 - OUT_W;
    localparam logic [NBT_W-1:0] NBT_FULL = NBT_W'(OUT_W);

    state_t state_q, state_d;
    logic [IN_W-1:0]  mant_q, mant_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [NBT_W-1:0] nbt_q, nbt_d;
    logic [OUT_W-1:0] kept_q, kept_d;
    logic             guard_q, guard_d;
    logic             sticky_q, sticky_d;
    logic             lsb_q, lsb_d;
    logic [OUT_W-1:0] mant_out_q, mant_out_d;
    logic             round_cy_q, round_cy_d;
    logic             inexact_q, inexact_d;
    logic             done_q;

    logic [OUT_W-1:0] ext, mask, lsb_oh, stk_mask;
    logic [LOW_W-1:0] low;
    logic             rnd_up;
    logic [OUT_W:0]   sum;
    logic             unused_top;

    assign ext        = mant_q[IN_W-3 -: OUT_W];
    assign low        = mant_q[LOW_W-1:0];
    assign unused_top = ^mant_q[IN_W-1:IN_W-2];

    round_mask_gen #(
        .OUT_W (OUT_W),
        .NBT_W (NBT_W)
    ) u_mask_gen (
        .nbt_i      (nbt_q),
        .mask_o     (mask),
        .lsb_oh_o   (lsb_oh),
        .stk_mask_o (stk_mask)
    );

`ifdef POSIT_ROUND_RNE_EN
    assign rnd_up = (nbt_q != '0) && guard_q && (sticky_q || lsb_q);
`else
    logic unused_lsb;
    assign rnd_up     = 1'b0;
    assign unused_lsb = lsb_q;
`endif

    assign sum = {1'b0, kept_q} + ({{OUT_W{1'b0}}, rnd_up} << (OUT_W - int'(nbt_q)));

    always_comb begin
        state_d    = state_q;
        mant_d     = mant_q;
        k_d        = k_q;
        nbt_d      = nbt_q;
        kept_d     = kept_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        lsb_d      = lsb_q;
        mant_out_d = mant_out_q;
        round_cy_d = round_cy_q;
        inexact_d  = inexact_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    mant_d  = mant_in;
                    k_d     = k_in;
                end
            end
            LOAD: begin
                state_d = MASK;
                nbt_d   = NBT_W'(nbt_calc(int'($signed(k_q)), K_W, NBT_POS, NBT_NEG, OUT_W));
            end
            MASK: begin
                state_d = ROUND;
                kept_d  = ext & mask;
                lsb_d   = |(ext & lsb_oh);
                // full-width keep: guard and sticky come entirely from below the window
                if (nbt_q == NBT_FULL) begin
                    guard_d  = low[LOW_W-1];
                    sticky_d = |low[LOW_W-2:0];
                end else begin
                    guard_d  = |(ext & ~mask & ~stk_mask);
                    sticky_d = (|(ext & stk_mask)) | (|low);
                end
            end
            ROUND: begin
                state_d    = DONE;
                mant_out_d = sum[OUT_W-1:0];
                round_cy_d = sum[OUT_W];
                inexact_d  = guard_q | sticky_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mant_q     <= '0;
            k_q        <= '0;
            nbt_q      <= '0;
            kept_q     <= '0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            lsb_q      <= 1'b0;
            mant_out_q <= '0;
            round_cy_q <= 1'b0;
            inexact_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mant_q     <= mant_d;
            k_q        <= k_d;
            nbt_q      <= nbt_d;
            kept_q     <= kept_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
            lsb_q      <= lsb_d;
            mant_out_q <= mant_out_d;
            round_cy_q <= round_cy_d;
            inexact_q  <= inexact_d;
            done_q     <= (state_q == DONE);
        end
    end

    assign mant_out = mant_out_q;
    assign round_cy = round_cy_q;
    assign inexact  = inexact_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_posit_frac_round_p.sv
// Directed bench for posit_frac_round_p; expectations follow POSIT_ROUND_RNE_EN when defined.
module tb_posit_frac_round_p;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] mant_in;
    logic [5:0]  k_in;
    logic [31:0] mant_out;
    logic        round_cy;
    logic        inexact;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    posit_frac_round_p dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mant_in  (mant_in),
        .k_in     (k_in),
        .mant_out (mant_out),
        .round_cy (round_cy),
        .inexact  (inexact),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // lat = rising edges from acceptance to the first negedge where done is seen
    task automatic run_op(input logic [63:0] m, input logic [5:0] k, output int lat);
        @(negedge clk);
        start   = 1'b1;
        mant_in = m;
        k_in    = k;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_vec(input string tag, input logic [1:0] top, input logic [31:0] ext,
                          input logic [29:0] low, input logic [5:0] k,
                          input logic [31:0] t_m, input logic t_x,
                          input logic [31:0] r_m, input logic r_c, input logic r_x);
        int          lat;
        logic [31:0] e_m;
        logic        e_c;
        logic        e_x;
`ifdef POSIT_ROUND_RNE_EN
        e_m = r_m; e_c = r_c; e_x = r_x;
`else
        e_m = t_m; e_c = 1'b0; e_x = t_x;
        if (r_c) e_c = 1'b0;
`endif
        run_op({top, ext, low}, k, lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'd4);
        check_eq({tag, "_mant"}, 64'(mant_out), 64'(e_m));
        check_eq({tag, "_cy"}, 64'(round_cy), 64'(e_c));
        check_eq({tag, "_inx"}, 64'(inexact), 64'(e_x));
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n_done;
        int n_busy;
        int first_done;
        int d_idx[3];
        int lat;

        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        mant_in = '0;
        k_in    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_mant", 64'(mant_out), 64'd0);
        check_eq("rst_cy", 64'(round_cy), 64'd0);
        check_eq("rst_inx", 64'(inexact), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        //     tag    top    ext            low            k      trunc_m        t_x   rne_m          cy    r_x
        do_vec("v1",  2'b00, 32'hFFFF_FFFF, 30'h0,         6'h00, 32'hFFFF_FFC0, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        do_vec("v2",  2'b00, 32'h0000_0060, 30'h0,         6'h00, 32'h0000_0040, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
        do_vec("v3",  2'b00, 32'h0000_0020, 30'h0,         6'h00, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        do_vec("v4",  2'b00, 32'h0000_0020, 30'h0,         6'h3F, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        do_vec("v5",  2'b00, 32'h0000_0001, 30'h0,         6'h1F, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        do_vec("v6",  2'b00, 32'h1234_5678, 30'h0,         6'h20, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
        do_vec("v7",  2'b00, 32'h1234_5679, 30'h2000_0000, 6'h20, 32'h1234_5679, 1'b1, 32'h1234_567A, 1'b0, 1'b1);
        do_vec("v8",  2'b00, 32'hFFFF_FFFF, 30'h2000_0001, 6'h20, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        do_vec("v9",  2'b11, 32'h0000_0040, 30'h0,         6'h00, 32'h0000_0040, 1'b0, 32'h0000_0040, 1'b0, 1'b0);
        do_vec("v10", 2'b00, 32'h0000_0040, 30'h1,         6'h00, 32'h0000_0040, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
        do_vec("v11", 2'b00, 32'h0000_0C00, 30'h0,         6'h05, 32'h0000_0800, 1'b1, 32'h0000_1000, 1'b0, 1'b1);
        do_vec("v12", 2'b00, 32'h0000_0180, 30'h0,         6'h3D, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 1'b1);

        // start held through the DONE cycle: exactly one operation
        @(negedge clk);
        start = 1'b1; mant_in = {2'b00, 32'h0000_0060, 30'h0}; k_in = 6'h00;
        n_done = 0; n_busy = 0; first_done = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
            if (i == 4) start = 1'b0;
        end
        check_eq("hold_ndone", 64'(n_done), 64'd1);
        check_eq("hold_tdone", 64'(first_done), 64'd4);
        check_eq("hold_nbusy", 64'(n_busy), 64'd4);

        // back-to-back requests
        @(negedge clk);
        start = 1'b1;
        n_done = 0;
        d_idx = '{-1, -1, -1};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) begin
                if (n_done < 3) d_idx[n_done] = i;
                n_done++;
            end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("b2b_ndone", 64'(n_done), 64'd3);
        check_eq("b2b_first", 64'(d_idx[0]), 64'd4);
        check_eq("b2b_gap1", 64'(d_idx[1] - d_idx[0]), 64'd5);
        check_eq("b2b_gap2", 64'(d_idx[2] - d_idx[1]), 64'd5);
        check_eq("b2b_idle", 64'(busy), 64'd0);

        // reset asserted during MASK after a nonzero result
        do_vec("pre", 2'b00, 32'h0000_0180, 30'h0, 6'h3D, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1; mant_in = {2'b00, 32'hFFFF_FFFF, 30'h0}; k_in = 6'h00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("rstm_busy", 64'(busy), 64'd0);
        check_eq("rstm_mant", 64'(mant_out), 64'd0);
        check_eq("rstm_inx", 64'(inexact), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("rstm_nodone", 64'(n_done), 64'd0);
        do_vec("post", 2'b00, 32'h0000_0060, 30'h0, 6'h00, 32'h0000_0040, 1'b1, 32'h0000_0080, 1'b0, 1'b1);

        run_op({2'b00, 32'h0000_0C00, 30'h0}, 6'h05, lat);
        check_eq("last_lat", 64'(lat), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
